// File: rtl/tx_packet_builder_if.sv
// rtl/tx_packet_builder_if.sv - memory read port and packet stream bundle for tx_packet_builder
interface tx_packet_builder_if #(
  parameter int WORD_WIDTH = 16
);
  logic [WORD_WIDTH-1:0] address;
  logic                  wr_en;
  logic [WORD_WIDTH-1:0] mem_data_out;
  logic [WORD_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  tx_last;

  // Builder side: drives the memory address and the packet stream.
  modport master (
    output address,
    output wr_en,
    input  mem_data_out,
    output tx_data,
    output tx_valid,
    input  tx_ready,
    output tx_last
  );

  // Memory / radio side.
  modport slave (
    input  address,
    input  wr_en,
    output mem_data_out,
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    input  tx_last
  );
endinterface

// File: rtl/tx_packet_builder.sv
// rtl/tx_packet_builder.sv - reads the known-sink table and streams a routing/feedback packet
module tx_packet_builder #(
  parameter int                    WORD_WIDTH      = 16,
  parameter logic [WORD_WIDTH-1:0] SINK_COUNT_ADDR = 'h0688,
  parameter logic [WORD_WIDTH-1:0] SINK_BASE_ADDR  = 'h0008,
  parameter int                    MAX_SINKS       = 16
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] my_node_id,
  input  logic [WORD_WIDTH-1:0] my_battery_stat,
  input  logic [WORD_WIDTH-1:0] my_value,
  input  logic [WORD_WIDTH-1:0] my_cluster_id,
  input  logic [WORD_WIDTH-1:0] nexthop,
  output logic                  done,
  tx_packet_builder_if.master   bus
);

  // Count width holds 0..MAX_SINKS; the sink index shares it.
  localparam int CW = $clog2(MAX_SINKS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CNT,
    S_LAT_CNT,
    S_SEND_HDR,
    S_RD_SINK,
    S_LAT_SINK,
    S_SEND_SINK,
    S_FIN
  } state_t;

  state_t                r_state;
  logic [WORD_WIDTH-1:0] r_src;
  logic [WORD_WIDTH-1:0] r_dst;
  logic [WORD_WIDTH-1:0] r_bat;
  logic [WORD_WIDTH-1:0] r_val;
  logic [WORD_WIDTH-1:0] r_clu;
  logic [CW-1:0]         r_n;
  logic [2:0]            r_idx;
  logic [CW-1:0]         r_j;
  logic [WORD_WIDTH-1:0] r_address;
  logic [WORD_WIDTH-1:0] r_tx_data;
  logic                  r_tx_valid;
  logic                  r_tx_last;
  logic                  r_done;

  logic                  w_xfer;
  logic [CW-1:0]         w_n_cap;
  logic [2:0]            w_idx_next;
  logic [WORD_WIDTH-1:0] w_hdr_word;
  logic [CW-1:0]         w_j_next;
  logic [WORD_WIDTH-1:0] w_sink_addr_next;
  logic                  w_sink_last;

  assign w_xfer           = r_tx_valid && bus.tx_ready;
  assign w_idx_next       = r_idx + 3'd1;
  assign w_j_next         = r_j + CW'(1);
  assign w_sink_addr_next = SINK_BASE_ADDR + WORD_WIDTH'({w_j_next, 1'b0});
  assign w_sink_last      = (r_j == (r_n - CW'(1)));

  // Clamp the stored sink count to the table capacity (full-width compare).
  always_comb begin
    w_n_cap = bus.mem_data_out[CW-1:0];
    if (bus.mem_data_out > WORD_WIDTH'(MAX_SINKS)) begin
      w_n_cap = CW'(MAX_SINKS);
    end
  end

  // Header word that follows the one currently on the stream (W1..W5).
  always_comb begin
    w_hdr_word = WORD_WIDTH'(r_n);
    case (w_idx_next)
      3'd1:    w_hdr_word = r_dst;
      3'd2:    w_hdr_word = r_bat;
      3'd3:    w_hdr_word = r_val;
      3'd4:    w_hdr_word = r_clu;
      default: w_hdr_word = WORD_WIDTH'(r_n);
    endcase
  end

  // Packet sequencer: every output is registered so the stream holds steady under stalls.
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_src      <= '0;
      r_dst      <= '0;
      r_bat      <= '0;
      r_val      <= '0;
      r_clu      <= '0;
      r_n        <= '0;
      r_idx      <= '0;
      r_j        <= '0;
      r_address  <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_tx_last  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_address  <= '0;
          r_tx_valid <= 1'b0;
          r_tx_last  <= 1'b0;
          if (start) begin
            r_src     <= my_node_id;
            r_dst     <= nexthop;
            r_bat     <= my_battery_stat;
            r_val     <= my_value;
            r_clu     <= my_cluster_id;
            r_done    <= 1'b0;
            r_address <= SINK_COUNT_ADDR;
            r_state   <= S_RD_CNT;
          end
        end
        S_RD_CNT: begin
          r_state <= S_LAT_CNT;
        end
        S_LAT_CNT: begin
          // Count read data is on the bus now; W0 goes out next cycle.
          r_n        <= w_n_cap;
          r_idx      <= 3'd0;
          r_tx_data  <= r_src;
          r_tx_valid <= 1'b1;
          r_tx_last  <= 1'b0;
          r_state    <= S_SEND_HDR;
        end
        S_SEND_HDR: begin
          if (w_xfer) begin
            if (r_idx != 3'd5) begin
              r_idx     <= w_idx_next;
              r_tx_data <= w_hdr_word;
              r_tx_last <= (w_idx_next == 3'd5) && (r_n == '0);
            end else if (r_n == '0) begin
              r_tx_valid <= 1'b0;
              r_tx_last  <= 1'b0;
              r_state    <= S_FIN;
            end else begin
              r_j        <= '0;
              r_address  <= SINK_BASE_ADDR;
              r_tx_valid <= 1'b0;
              r_tx_last  <= 1'b0;
              r_state    <= S_RD_SINK;
            end
          end
        end
        S_RD_SINK: begin
          r_state <= S_LAT_SINK;
        end
        S_LAT_SINK: begin
          r_tx_data  <= bus.mem_data_out;
          r_tx_valid <= 1'b1;
          r_tx_last  <= w_sink_last;
          r_state    <= S_SEND_SINK;
        end
        S_SEND_SINK: begin
          if (w_xfer) begin
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            if (w_sink_last) begin
              r_state <= S_FIN;
            end else begin
              r_j       <= w_j_next;
              r_address <= w_sink_addr_next;
              r_state   <= S_RD_SINK;
            end
          end
        end
        S_FIN: begin
          r_done    <= 1'b1;
          r_address <= '0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.address  = r_address;
  assign bus.wr_en    = 1'b0;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;
  assign bus.tx_last  = r_tx_last;
  assign done         = r_done;

endmodule

// File: tb/tb_tx_packet_builder.sv
// tb/tb_tx_packet_builder.sv - randomized self-checking bench for tx_packet_builder
module tb_tx_packet_builder;

  logic        clock = 1'b0;
  logic        nrst  = 1'b0;
  logic        start = 1'b0;
  logic [15:0] my_node_id = '0;
  logic [15:0] my_battery_stat = '0;
  logic [15:0] my_value = '0;
  logic [15:0] my_cluster_id = '0;
  logic [15:0] nexthop = '0;
  logic        done;

  tx_packet_builder_if #(.WORD_WIDTH(16)) bus_if ();

  tx_packet_builder #(
    .WORD_WIDTH(16),
    .SINK_COUNT_ADDR(16'h0688),
    .SINK_BASE_ADDR(16'h0008),
    .MAX_SINKS(16)
  ) dut (
    .clock(clock),
    .nrst(nrst),
    .start(start),
    .my_node_id(my_node_id),
    .my_battery_stat(my_battery_stat),
    .my_value(my_value),
    .my_cluster_id(my_cluster_id),
    .nexthop(nexthop),
    .done(done),
    .bus(bus_if)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Word-addressed memory model with one-cycle synchronous read.
  logic [15:0] mem [0:1023];
  always @(posedge clock) bus_if.mem_data_out <= mem[bus_if.address[10:1]];

  // tx_ready driver: 0 = always ready, 1 = random, 2 = two stall cycles per word.
  int ready_mode = 0;
  int stall_cnt  = 0;
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0: bus_if.tx_ready = 1'b1;
      1: bus_if.tx_ready = 1'($urandom_range(0, 1));
      default: begin
        if (bus_if.tx_valid) begin
          if (stall_cnt < 2) begin
            bus_if.tx_ready = 1'b0;
            stall_cnt++;
          end else begin
            bus_if.tx_ready = 1'b1;
            stall_cnt = 0;
          end
        end else begin
          bus_if.tx_ready = 1'b0;
          stall_cnt = 0;
        end
      end
    endcase
  end

  // Observer: records transfers, distinct addresses and stall-stability violations.
  logic [15:0] got_q[$];
  bit          last_q[$];
  logic [15:0] addr_q[$];
  int          stall_err = 0;
  int          wr_err = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_data = '0;
  logic        prev_last = 1'b0;
  logic [15:0] prev_addr = '0;
  always @(negedge clock) begin
    if (nrst) begin
      if (prev_stall && (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== prev_data ||
                         bus_if.tx_last !== prev_last))
        stall_err++;
      if (bus_if.tx_valid === 1'b1 && bus_if.tx_ready === 1'b1) begin
        got_q.push_back(bus_if.tx_data);
        last_q.push_back(bus_if.tx_last);
      end
      if (bus_if.address !== prev_addr && bus_if.address !== 16'h0000)
        addr_q.push_back(bus_if.address);
      if (bus_if.wr_en !== 1'b0) wr_err++;
      prev_stall = (bus_if.tx_valid === 1'b1) && (bus_if.tx_ready !== 1'b1);
      prev_data  = bus_if.tx_data;
      prev_last  = bus_if.tx_last;
      prev_addr  = bus_if.address;
    end else begin
      prev_stall = 0;
      prev_addr  = '0;
    end
  end

  // Reference model: packet = 5 fields, clamped count, then that many table entries.
  logic [15:0] exp_q[$];
  logic [15:0] exp_addr[$];
  task automatic build_model(input logic [15:0] f_src, input logic [15:0] f_dst,
                             input logic [15:0] f_bat, input logic [15:0] f_val,
                             input logic [15:0] f_clu, input logic [15:0] count);
    int n;
    n = (count > 16'd16) ? 16 : int'(count);
    exp_q = {};
    exp_q.push_back(f_src);
    exp_q.push_back(f_dst);
    exp_q.push_back(f_bat);
    exp_q.push_back(f_val);
    exp_q.push_back(f_clu);
    exp_q.push_back(16'(n));
    for (int i = 0; i < n; i++) exp_q.push_back(mem[4 + i]);
    exp_addr = {};
    exp_addr.push_back(16'h0688);
    for (int i = 0; i < n; i++) exp_addr.push_back(16'(16'h0008 + 2 * i));
  endtask

  task automatic load_table(input logic [15:0] count);
    mem[16'h0688 >> 1] = count;
    for (int i = 0; i < 17; i++) mem[4 + i] = 16'($urandom);
  endtask

  task automatic random_fields();
    my_node_id      = 16'($urandom);
    my_battery_stat = 16'($urandom);
    my_value        = 16'($urandom);
    my_cluster_id   = 16'($urandom);
    nexthop         = 16'($urandom);
  endtask

  task automatic model_from_inputs(input logic [15:0] count);
    build_model(my_node_id, nexthop, my_battery_stat, my_value, my_cluster_id, count);
  endtask

  task automatic pulse_start();
    @(posedge clock);
    #1;
    got_q = {};
    last_q = {};
    addr_q = {};
    stall_err = 0;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Waits for done; cycles counts edges after the start-accept edge.
  task automatic wait_done(output bit ok, output int cycles);
    ok = 0;
    cycles = 0;
    for (int c = 1; c <= 1500; c++) begin
      @(posedge clock);
      #1;
      if (done === 1'b1) begin
        ok = 1;
        cycles = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (bus_if.address !== 16'h0 || bus_if.tx_data !== 16'h0 || bus_if.tx_valid !== 1'b0 ||
        bus_if.tx_last !== 1'b0 || done !== 1'b0 || bus_if.wr_en !== 1'b0)
      $display("FAIL reset_state: addr=%h data=%h valid=%b last=%b done=%b wr=%b, required all 0",
               bus_if.address, bus_if.tx_data, bus_if.tx_valid, bus_if.tx_last, done, bus_if.wr_en);
    else n_pass++;
    #16 nrst = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (bus_if.tx_valid !== 1'b0 || done !== 1'b0 || bus_if.address !== 16'h0)
      $display("FAIL idle_after_reset: valid=%b done=%b addr=%h, required 0/0/0000",
               bus_if.tx_valid, done, bus_if.address);
    else n_pass++;
  endtask

  task automatic test_zero_sinks();
    bit ok;
    int cyc;
    ready_mode = 0;
    my_node_id = 16'd3; nexthop = 16'd5; my_battery_stat = 16'h8000;
    my_value = 16'd10; my_cluster_id = 16'd1;
    load_table(16'd0);
    model_from_inputs(16'd0);
    pulse_start();
    wait_done(ok, cyc);
    n_checks++;
    if (!ok || cyc != 9) $display("FAIL zero_done_latency: got ok=%0d cycles=%0d, required 9", ok, cyc);
    else n_pass++;
    n_checks++;
    if (got_q.size() != 6) $display("FAIL zero_len: got %0d words, required 6", got_q.size());
    else n_pass++;
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 5))
        $display("FAIL zero_word%0d: got %h last=%b, required %h last=%b", i, got_q[i], last_q[i], exp_q[i], i == 5);
      else n_pass++;
    end
    n_checks++;
    if (addr_q.size() != 1 || addr_q[0] !== 16'h0688)
      $display("FAIL zero_addr: got %0d addresses first=%h, required 1 at 0688", addr_q.size(),
               (addr_q.size() > 0) ? addr_q[0] : 16'hxxxx);
    else n_pass++;
  endtask

  task automatic test_three_sinks();
    bit ok;
    int cyc;
    bit good;
    ready_mode = 0;
    random_fields();
    load_table(16'd3);
    mem[4] = 16'h0007; mem[5] = 16'h0009; mem[6] = 16'h000B;
    model_from_inputs(16'd3);
    pulse_start();
    wait_done(ok, cyc);
    n_checks++;
    if (!ok || got_q.size() != 9) $display("FAIL three_len: got ok=%0d words=%0d, required 9", ok, got_q.size());
    else n_pass++;
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 8))
        $display("FAIL three_word%0d: got %h last=%b, required %h last=%b", i, got_q[i], last_q[i], exp_q[i], i == 8);
      else n_pass++;
    end
    good = (addr_q.size() == 4);
    for (int i = 0; i < 4 && good; i++) if (addr_q[i] !== exp_addr[i]) good = 0;
    n_checks++;
    if (!good) $display("FAIL three_addr: got %0d addresses, required 0688,0008,000A,000C", addr_q.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    int bad;
    ready_mode = 2;
    random_fields();
    load_table(16'd2);
    model_from_inputs(16'd2);
    pulse_start();
    wait_done(ok, cyc);
    n_checks++;
    if (!ok || got_q.size() != 8) $display("FAIL bp_len: got ok=%0d words=%0d, required 8", ok, got_q.size());
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 7)) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL bp_words: got %0d wrong words, required 0", bad);
    else n_pass++;
    n_checks++;
    if (stall_err != 0) $display("FAIL bp_stable: got %0d unstable stall cycles, required 0", stall_err);
    else n_pass++;
    ready_mode = 0;
  endtask

  task automatic test_clamp();
    bit ok;
    int cyc;
    bit good;
    ready_mode = 0;
    random_fields();
    load_table(16'h0014);
    model_from_inputs(16'h0014);
    pulse_start();
    wait_done(ok, cyc);
    n_checks++;
    if (!ok || got_q.size() != 22) $display("FAIL clamp_len: got ok=%0d words=%0d, required 22", ok, got_q.size());
    else n_pass++;
    n_checks++;
    if (got_q.size() > 5 && got_q[5] !== 16'h0010) $display("FAIL clamp_w5: got %h, required 0010", got_q[5]);
    else n_pass++;
    good = (got_q.size() == 22);
    for (int i = 0; i < 22 && good; i++) if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 21)) good = 0;
    n_checks++;
    if (!good) $display("FAIL clamp_words: packet differs from model (%0d words)", got_q.size());
    else n_pass++;
    good = (addr_q.size() == 17);
    for (int i = 0; i < 17 && good; i++) if (addr_q[i] !== exp_addr[i]) good = 0;
    n_checks++;
    if (!good) $display("FAIL clamp_addr: got %0d addresses last=%h, required 17 ending 0026", addr_q.size(),
                        (addr_q.size() > 0) ? addr_q[addr_q.size() - 1] : 16'hxxxx);
    else n_pass++;
  endtask

  task automatic test_random();
    bit ok;
    int cyc;
    bit good;
    logic [15:0] cnt;
    for (int t = 0; t < 6; t++) begin
      ready_mode = 1;
      cnt = (t == 0) ? 16'hFFFF : 16'($urandom_range(0, 20));
      random_fields();
      load_table(cnt);
      model_from_inputs(cnt);
      wr_err = 0;
      pulse_start();
      wait_done(ok, cyc);
      good = ok && (got_q.size() == exp_q.size());
      for (int i = 0; i < exp_q.size() && good; i++)
        if (got_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) good = 0;
      n_checks++;
      if (!good) $display("FAIL rand%0d_packet: got %0d words, required %0d (count=%h)", t, got_q.size(), exp_q.size(), cnt);
      else n_pass++;
      good = (addr_q.size() == exp_addr.size());
      for (int i = 0; i < exp_addr.size() && good; i++) if (addr_q[i] !== exp_addr[i]) good = 0;
      n_checks++;
      if (!good || stall_err != 0 || wr_err != 0)
        $display("FAIL rand%0d_bus: addrs=%0d (required %0d) stall_err=%0d wr_err=%0d", t, addr_q.size(), exp_addr.size(), stall_err, wr_err);
      else n_pass++;
    end
    ready_mode = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc;
    bit good;
    ready_mode = 0;
    random_fields();
    load_table(16'd4);
    model_from_inputs(16'd4);
    pulse_start();
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clock);
      #1;
      if (got_q.size() >= 7) begin ok = 1; break; end
    end
    n_checks++;
    if (!ok) $display("FAIL rstmid_reach_w7: got %0d words before timeout, required 7", got_q.size());
    else n_pass++;
    @(negedge clock);
    #2 nrst = 1'b0;
    #3;
    n_checks++;
    if (bus_if.address !== 16'h0 || bus_if.tx_data !== 16'h0 || bus_if.tx_valid !== 1'b0 ||
        bus_if.tx_last !== 1'b0 || done !== 1'b0)
      $display("FAIL rstmid_async: addr=%h data=%h valid=%b last=%b done=%b, required all 0",
               bus_if.address, bus_if.tx_data, bus_if.tx_valid, bus_if.tx_last, done);
    else n_pass++;
    #22 nrst = 1'b1;
    pulse_start();
    wait_done(ok, cyc);
    good = ok && (got_q.size() == exp_q.size());
    for (int i = 0; i < exp_q.size() && good; i++)
      if (got_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) good = 0;
    n_checks++;
    if (!good) $display("FAIL rstmid_restart: got %0d words first=%h, required %0d from W0=%h", got_q.size(),
                        (got_q.size() > 0) ? got_q[0] : 16'hxxxx, exp_q.size(), exp_q[0]);
    else n_pass++;
  endtask

  task automatic test_ignore_start();
    bit ok;
    int cyc;
    bit good;
    ready_mode = 1;
    random_fields();
    load_table(16'd3);
    model_from_inputs(16'd3);
    pulse_start();
    for (int c = 0; c < 300; c++) begin
      @(posedge clock);
      #1;
      if (got_q.size() >= 6) break;
    end
    start = 1'b1;
    random_fields();
    @(posedge clock);
    #1;
    start = 1'b0;
    random_fields();
    wait_done(ok, cyc);
    good = ok && (got_q.size() == exp_q.size());
    for (int i = 0; i < exp_q.size() && good; i++)
      if (got_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) good = 0;
    n_checks++;
    if (!good) $display("FAIL ignore_packet: got %0d words, required %0d with first-start fields", got_q.size(), exp_q.size());
    else n_pass++;
    repeat (20) @(posedge clock);
    #1;
    n_checks++;
    if (got_q.size() != 9 || done !== 1'b1)
      $display("FAIL ignore_single: got %0d words done=%b, required 9 words done=1", got_q.size(), done);
    else n_pass++;
    ready_mode = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    test_reset();
    test_zero_sinks();
    test_three_sinks();
    test_backpressure();
    test_clamp();
    test_random();
    test_reset_mid();
    test_ignore_start();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
